mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one synchronous memory port (DataMem-style: Address, writeData, MemRead, MemWrite, ReadData) between two requesters:
  - the instruction-fetch stage (read-only);
  - the data-memory stage (read/write).
- Sits between the multi-cycle core and a unified memory. Sequences each access as ISSUE then DONE, and arbitrates so neither port starves.
- Keeps saturating per-port grant counters for performance debug.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width.
- CNT_W, 16, width of the saturating grant counters.

Ports:
- Clk  input  1  system clock; all state updates on posedge.
- Reset  input  1  asynchronous, active-high reset.
- IReq  input  1  fetch request; held with IAddr stable until IReady.
- IAddr  input  ADDR_W  fetch address (byte address, Pc).
- IReady  output  1  one-cycle pulse; fetch complete, IData valid.
- IData  output  DATA_W  fetched instruction; holds the last value between fetches.
- DReq  input  1  data request; held with DWrite/DAddr/DWData stable until DReady.
- DWrite  input  1  1 = write, 0 = read.
- DAddr  input  ADDR_W  data address.
- DWData  input  DATA_W  write data.
- DReady  output  1  one-cycle pulse; data access complete.
- DRData  output  DATA_W  read data; holds the last read value; unchanged by writes.
- MemAddr  output  ADDR_W  to memory Address.
- MemWData  output  DATA_W  to memory writeData.
- MemRead  output  1  to memory read enable.
- MemWrite  output  1  to memory write enable.
- MemRData  input  DATA_W  from memory ReadData; valid in the cycle after the read strobe.
- Busy  output  1  high in ISSUE or DONE.
- ICount  output  CNT_W  number of completed fetches, saturating.
- DCount  output  CNT_W  number of completed data accesses, saturating.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE.
  - IReady, DReady, MemRead, MemWrite, Busy = 0.
  - IData, DRData, MemAddr, MemWData, ICount, DCount = 0.
  - Owner register = I.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - DReq=1 -> ISSUE with owner D. Data has priority, so a load/store is never blocked by a fetch.
  - Otherwise IReq=1 -> ISSUE with owner I.
  - Otherwise stay in IDLE.
  - On entering ISSUE: latch the owner's address, write data and DWrite into internal registers. MemAddr and MemWData are driven from these latches.
- ISSUE (exactly 1 cycle):
  - Owner D with DWrite=1: MemWrite=1.
  - Otherwise: MemRead=1.
  - Next state is always DONE.
- DONE (exactly 1 cycle):
  - MemRead=0 and MemWrite=0.
  - Owner's Ready = 1, combinational from state.
  - On reads, IData/DRData = MemRdata passed through. The holding register loads MemRData at the DONE-ending posedge.
  - Owner's counter increments, stopping at all-ones.
  - Next-state arbitration ignores the owner's own Req, which is still high this cycle:
    - the other port requesting -> ISSUE for the other port, with a new latch;
    - else -> IDLE.
  - This gives strict alternation under contention.
- Latency and throughput:
  - From IDLE: Ready is asserted 2 cycles after Req is first seen high at a posedge.
  - Back-to-back throughput is 1 access per 2 cycles.
  - Under full contention, I and D alternate: D, I, D, I, ...
- Boundary conditions:
  - Address and data changes while in ISSUE/DONE are ignored; the latch is authoritative.
  - A requester that drops Req before Ready is still served. Its Ready pulse is produced and may be ignored.
  - Reset mid-access aborts the access immediately. A strobe in ISSUE drops asynchronously, and no Ready is produced. A write may or may not have reached memory. A still-asserted Req is re-served from IDLE after Reset falls.
  - IReady and DReady are never high in the same cycle. MemRead and MemWrite are never high together.
  - Counter saturation: at all-ones, further completions leave the value unchanged.

Test Plan:
- Reset, then IReq=1 with IAddr=0 held:
  - MemRead=1 with MemAddr=0 at cycle 1;
  - IReady=1 with IData=mem[0] at cycle 2;
  - ICount=1.
- DReq=1, DWrite=1, DAddr=8, DWData=0xA5A5A5A5, followed by a read of address 8:
  - MemWrite pulses once;
  - the read returns DRData=0xA5A5A5A5;
  - DRData is unchanged after the write's DReady.
- IReq and DReq rise together and are held for 4 accesses:
  - grant order is D, I, D, I;
  - Ready pulses arrive at cycles 2, 4, 6, 8;
  - no cycle has both Ready signals high.
- DAddr changes from 8 to 12 during ISSUE:
  - MemAddr stays 8 through the access.
- Reset asserted mid-ISSUE of a read:
  - MemRead falls without waiting for a clock edge;
  - no DReady is produced;
  - after release with DReq still high, the read completes 2 cycles later.
- Preload ICount to near-saturation with CNT_W=4 and run 20 fetches:
  - ICount ends at 15.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one synchronous memory port between fetch and data
//            requesters with an ISSUE/DONE sequence and alternating grants.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic              IReady,
    output logic [DATA_W-1:0] IData,
    input  logic              DReq,
    input  logic              DWrite,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic              DReady,
    output logic [DATA_W-1:0] DRData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemRData,
    output logic              Busy,
    output logic [CNT_W-1:0]  ICount,
    output logic [CNT_W-1:0]  DCount
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load;
    logic              w_load_d;
    logic              r_owner_d;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_idata;
    logic [DATA_W-1:0] r_drdata;
    logic [CNT_W-1:0]  r_icnt;
    logic [CNT_W-1:0]  r_dcnt;
    logic              w_iready;
    logic              w_dready;

    // In DONE the owner's own request is still high, so only the other port
    // is considered; this is what forces alternation under contention.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_d    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (DReq) begin
                    w_state_nxt = S_ISSUE;
                    w_load      = 1'b1;
                    w_load_d    = 1'b1;
                end else if (IReq) begin
                    w_state_nxt = S_ISSUE;
                    w_load      = 1'b1;
                end
            end
            S_ISSUE: w_state_nxt = S_DONE;
            S_DONE: begin
                if (r_owner_d && IReq) begin
                    w_state_nxt = S_ISSUE;
                    w_load      = 1'b1;
                end else if (!r_owner_d && DReq) begin
                    w_state_nxt = S_ISSUE;
                    w_load      = 1'b1;
                    w_load_d    = 1'b1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_owner_d <= 1'b0;
            r_wr      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_idata   <= '0;
            r_drdata  <= '0;
            r_icnt    <= '0;
            r_dcnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_owner_d <= w_load_d;
                r_addr    <= w_load_d ? DAddr : IAddr;
                r_wr      <= w_load_d & DWrite;
                if (w_load_d) begin
                    r_wdata <= DWData;
                end
            end
            if (w_iready) begin
                r_idata <= MemRData;
                if (r_icnt != {CNT_W{1'b1}}) begin
                    r_icnt <= r_icnt + 1'b1;
                end
            end
            if (w_dready) begin
                if (!r_wr) begin
                    r_drdata <= MemRData;
                end
                if (r_dcnt != {CNT_W{1'b1}}) begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end
        end
    end

    // Strobes and Ready decode from state so an asynchronous reset drops them at once.
    assign w_iready = (r_state == S_DONE) && !r_owner_d;
    assign w_dready = (r_state == S_DONE) &&  r_owner_d;

    assign IReady   = w_iready;
    assign DReady   = w_dready;
    assign IData    = w_iready ? MemRData : r_idata;
    assign DRData   = (w_dready && !r_wr) ? MemRData : r_drdata;
    assign MemAddr  = r_addr;
    assign MemWData = r_wdata;
    assign MemRead  = (r_state == S_ISSUE) && !(r_owner_d && r_wr);
    assign MemWrite = (r_state == S_ISSUE) &&  (r_owner_d && r_wr);
    assign Busy     = (r_state != S_IDLE);
    assign ICount   = r_icnt;
    assign DCount   = r_dcnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter with a word memory and
//            a transaction-level reference of contents, data and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int C_AW  = 32;
    localparam int C_DW  = 32;
    localparam int C_CW  = 4;
    localparam int C_SAT = 15;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            IReq = 1'b0;
    logic [C_AW-1:0] IAddr = '0;
    logic            IReady;
    logic [C_DW-1:0] IData;
    logic            DReq = 1'b0;
    logic            DWrite = 1'b0;
    logic [C_AW-1:0] DAddr = '0;
    logic [C_DW-1:0] DWData = '0;
    logic            DReady;
    logic [C_DW-1:0] DRData;
    logic [C_AW-1:0] MemAddr;
    logic [C_DW-1:0] MemWData;
    logic            MemRead;
    logic            MemWrite;
    logic [C_DW-1:0] MemRData = '0;
    logic            Busy;
    logic [C_CW-1:0] ICount;
    logic [C_CW-1:0] DCount;

    int vectors = 0;
    int miscompares = 0;

    mem_port_arbiter #(.ADDR_W(C_AW), .DATA_W(C_DW), .CNT_W(C_CW)) dut (
        .Clk(Clk), .Reset(Reset),
        .IReq(IReq), .IAddr(IAddr), .IReady(IReady), .IData(IData),
        .DReq(DReq), .DWrite(DWrite), .DAddr(DAddr), .DWData(DWData),
        .DReady(DReady), .DRData(DRData),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemRData(MemRData),
        .Busy(Busy), .ICount(ICount), .DCount(DCount)
    );

    always #5 Clk = ~Clk;

    // Synchronous word memory: unwritten words hold a seeded pattern.
    logic [31:0] seed = 32'h0;
    logic [31:0] wmem [64];
    bit   [63:0] wvalid;

    function automatic logic [31:0] init_word(input int i);
        return seed ^ (32'(i) * 32'h9E3779B9);
    endfunction

    always @(posedge Clk) begin
        if (MemWrite) begin
            wmem[MemAddr[7:2]]   <= MemWData;
            wvalid[MemAddr[7:2]] <= 1'b1;
        end
        if (MemRead) begin
            MemRData <= wvalid[MemAddr[7:2]] ? wmem[MemAddr[7:2]] : init_word(int'(MemAddr[7:2]));
        end
    end

    // Reference: expected memory contents, holding values and counters.
    logic [31:0] ref_mem [64];
    logic [31:0] exp_idata  = '0;
    logic [31:0] exp_drdata = '0;
    int          exp_icnt   = 0;
    int          exp_dcnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            chk("ready_exclusive", 32'(IReady && DReady), 32'd0);
            chk("strobe_exclusive", 32'(MemRead && MemWrite), 32'd0);
        end
    end

    // One uncontended access from IDLE; inputs change and outputs are sampled at negedges.
    task automatic access(input bit d, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        int idx = int'(addr[7:2]);
        if (d) begin
            DReq = 1'b1; DWrite = wr; DAddr = addr; DWData = wd;
        end else begin
            IReq = 1'b1; IAddr = addr;
        end
        @(negedge Clk);
        chk("issue_read",  32'(MemRead),  32'(!(d && wr)));
        chk("issue_write", 32'(MemWrite), 32'(d && wr));
        chk("issue_addr",  MemAddr, addr);
        if (d && wr) chk("issue_wdata", MemWData, wd);
        @(negedge Clk);
        chk("done_iready", 32'(IReady), 32'(!d));
        chk("done_dready", 32'(DReady), 32'(d));
        chk("done_strobes", 32'({MemRead, MemWrite}), 32'd0);
        if (d) begin
            DReq = 1'b0;
            if (wr) ref_mem[idx] = wd;
            else    exp_drdata   = ref_mem[idx];
            chk("done_drdata", DRData, exp_drdata);
            exp_dcnt = (exp_dcnt < C_SAT) ? exp_dcnt + 1 : C_SAT;
        end else begin
            IReq = 1'b0;
            exp_idata = ref_mem[idx];
            chk("done_idata", IData, exp_idata);
            exp_icnt = (exp_icnt < C_SAT) ? exp_icnt + 1 : C_SAT;
        end
        @(negedge Clk);
        chk("after_busy",   32'(Busy), 32'd0);
        chk("after_icount", 32'(ICount), 32'(exp_icnt));
        chk("after_dcount", 32'(DCount), 32'(exp_dcnt));
        chk("after_idata",  IData,  exp_idata);
        chk("after_drdata", DRData, exp_drdata);
    endtask

    initial begin
        logic [31:0] ia;
        logic [31:0] da;
        seed = $urandom;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_strobes", 32'({IReady, DReady, MemRead, MemWrite, Busy}), 32'd0);
        chk("rst_idata",   IData,  32'd0);
        chk("rst_drdata",  DRData, 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_wdata",   MemWData, 32'd0);
        chk("rst_counts",  32'({ICount, DCount}), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Fetch from address 0, then a store of 0xA5A5A5A5 and its readback
        access(1'b0, 1'b0, 32'd0, 32'd0);
        access(1'b1, 1'b0, 32'd4, 32'd0);
        access(1'b1, 1'b1, 32'd8, 32'hA5A5A5A5);
        access(1'b1, 1'b0, 32'd8, 32'd0);
        chk("readback_a5", exp_drdata, 32'hA5A5A5A5);

        // Full contention: grants D, I, D, I with Ready at cycles 2, 4, 6, 8
        ia = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        da = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
        IReq = 1'b1; IAddr = ia; DReq = 1'b1; DWrite = 1'b0; DAddr = da;
        for (int c = 1; c <= 8; c++) begin
            @(negedge Clk);
            chk($sformatf("cont_dready_c%0d", c), 32'(DReady), 32'(c % 4 == 2));
            chk($sformatf("cont_iready_c%0d", c), 32'(IReady), 32'(c % 4 == 0));
            if (c % 2 == 1) chk($sformatf("cont_addr_c%0d", c), MemAddr, (c % 4 == 1) ? da : ia);
            if (c % 4 == 2) chk($sformatf("cont_drdata_c%0d", c), DRData, ref_mem[da[7:2]]);
            if (c % 4 == 0) chk($sformatf("cont_idata_c%0d", c), IData, ref_mem[ia[7:2]]);
        end
        IReq = 1'b0; DReq = 1'b0;
        exp_idata = ref_mem[ia[7:2]]; exp_drdata = ref_mem[da[7:2]];
        exp_icnt += 2; exp_dcnt += 2;
        @(negedge Clk);
        chk("cont_icount", 32'(ICount), 32'(exp_icnt));
        chk("cont_dcount", 32'(DCount), 32'(exp_dcnt));
        chk("cont_idle",   32'(Busy), 32'd0);

        // Address change during ISSUE is ignored
        DReq = 1'b1; DWrite = 1'b0; DAddr = 32'd8;
        @(negedge Clk);
        chk("latch_issue_addr", MemAddr, 32'd8);
        DAddr = 32'd12;
        @(negedge Clk);
        chk("latch_done_addr", MemAddr, 32'd8);
        chk("latch_drdata", DRData, 32'hA5A5A5A5);
        DReq = 1'b0; exp_drdata = 32'hA5A5A5A5; exp_dcnt++;
        @(negedge Clk);
        chk("latch_dcount", 32'(DCount), 32'(exp_dcnt));

        // Reset in the middle of ISSUE, request kept high throughout
        DReq = 1'b1; DWrite = 1'b0; DAddr = 32'd4;
        @(negedge Clk);
        chk("abort_pre_read", 32'(MemRead), 32'd1);
        #1 Reset = 1'b1;
        #1;
        chk("abort_read_async", 32'(MemRead), 32'd0);
        chk("abort_busy_async", 32'(Busy), 32'd0);
        exp_icnt = 0; exp_dcnt = 0; exp_idata = '0; exp_drdata = '0;
        @(negedge Clk);
        chk("abort_no_dready", 32'(DReady), 32'd0);
        chk("abort_counts", 32'({ICount, DCount}), 32'd0);
        chk("abort_drdata", DRData, 32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("resume_read", 32'(MemRead), 32'd1);
        chk("resume_addr", MemAddr, 32'd4);
        @(negedge Clk);
        chk("resume_dready", 32'(DReady), 32'd1);
        exp_drdata = ref_mem[1];
        chk("resume_drdata", DRData, exp_drdata);
        DReq = 1'b0; exp_dcnt = 1;
        @(negedge Clk);
        chk("resume_dcount", 32'(DCount), 32'(exp_dcnt));

        // Randomized traffic driving ICount into saturation
        for (int n = 0; n < 20; n++) begin
            access(1'b0, 1'b0, {24'd0, 6'($urandom_range(0, 63)), 2'b00}, 32'd0);
            if ($urandom_range(0, 1) == 1)
                access(1'b1, 1'($urandom_range(0, 1)), {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom);
        end
        chk("sat_icount", 32'(ICount), 32'(C_SAT));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
